// File: rtl/aes_key_schedule_ctrl.sv
// rtl/aes_key_schedule_ctrl.sv - iterative AES key expansion (one word per clock) with indexed round-key reads
module aes_key_schedule_ctrl #(
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [0:32*NK-1]  key,
  output logic              busy,
  output logic              done,
  input  logic              rk_req,
  input  logic [3:0]        rk_idx,
  output logic              rk_valid,
  output logic              rk_err,
  output logic [0:127]      rk
);

  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_READY} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_w [0:NW-1];
  logic [5:0]  r_i;
  logic [2:0]  r_mod;
  logic [7:0]  r_rcon;
  logic        r_done;
  logic        r_rk_valid;
  logic        r_rk_err;
  logic [0:127] r_rk;

  logic        w_accept;
  logic        w_last;
  logic        w_rd;
  logic        w_rk_ok;
  logic [5:0]  w_base;
  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic [31:0] w_temp;
  logic [31:0] w_new;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq, inv;
    sq  = b;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  assign key_ready = (r_state != S_EXPAND);
  assign busy      = (r_state == S_EXPAND);
  assign done      = r_done;
  assign rk_valid  = r_rk_valid;
  assign rk_err    = r_rk_err;
  assign rk        = r_rk;

  assign w_accept = key_valid && key_ready;
  assign w_last   = (r_state == S_EXPAND) && (r_i == 6'(NW - 1));
  assign w_rd     = (r_state == S_READY) && rk_req;
  assign w_rk_ok  = (rk_idx <= 4'(NR));
  assign w_base   = w_rk_ok ? {rk_idx, 2'b00} : 6'd0;

  assign w_prev = r_w[r_i - 6'd1];
  assign w_back = r_w[r_i - 6'(NK)];
  assign w_new  = w_back ^ w_temp;

  always_comb begin
    w_temp = w_prev;
    if (r_mod == 3'd0)
      w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h000000};
    else if (NK == 8 && r_mod == 3'd4)
      w_temp = sub_word(w_prev);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_EXPAND;
      S_EXPAND: if (w_last)   w_next = S_READY;
      S_READY:  if (w_accept) w_next = S_EXPAND;
      default:  w_next = S_IDLE;
    endcase
  end

  // Word file carries no reset; validity is tracked by the state alone
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int j = 0; j < NK; j++)
        r_w[j] <= key[32*j +: 32];
    end else if (r_state == S_EXPAND) begin
      r_w[r_i] <= w_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_i        <= 6'(NK);
      r_mod      <= 3'd0;
      r_rcon     <= 8'h01;
      r_done     <= 1'b0;
      r_rk_valid <= 1'b0;
      r_rk_err   <= 1'b0;
      r_rk       <= '0;
    end else begin
      r_state    <= w_next;
      r_done     <= w_last;
      r_rk_valid <= w_rd;
      if (w_accept) begin
        r_i    <= 6'(NK);
        r_mod  <= 3'd0;
        r_rcon <= 8'h01;
      end else if (r_state == S_EXPAND) begin
        r_i <= r_i + 6'd1;
        // r_mod tracks i mod NK; Rcon doubles in GF(2^8) each time it wraps
        if (r_mod == 3'(NK - 1)) begin
          r_mod  <= 3'd0;
          r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
        end else begin
          r_mod <= r_mod + 3'd1;
        end
      end
      if (w_rd) begin
        r_rk_err <= !w_rk_ok;
        r_rk     <= w_rk_ok ? {r_w[w_base], r_w[w_base + 6'd1],
                               r_w[w_base + 6'd2], r_w[w_base + 6'd3]} : '0;
      end else begin
        r_rk_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// tb/tb_aes_key_schedule_ctrl.sv - directed-vector bench for aes_key_schedule_ctrl at NK=4/6/8
module tb_aes_key_schedule_ctrl;

  logic         clk;
  logic         rst_b   [3];
  logic         kv      [3];
  logic         kr      [3];
  logic         busy_b  [3];
  logic         done_b  [3];
  logic         rq      [3];
  logic [3:0]   idx     [3];
  logic         rkv     [3];
  logic         rke     [3];
  logic [0:127] rk_b    [3];
  logic [0:255] key_b   [3];

  int n_vec  = 0;
  int n_miss = 0;

  aes_key_schedule_ctrl #(.NK(4)) u_nk4 (
    .clk(clk), .rst(rst_b[0]), .key_valid(kv[0]), .key_ready(kr[0]), .key(key_b[0][0:127]),
    .busy(busy_b[0]), .done(done_b[0]), .rk_req(rq[0]), .rk_idx(idx[0]),
    .rk_valid(rkv[0]), .rk_err(rke[0]), .rk(rk_b[0]));

  aes_key_schedule_ctrl #(.NK(6)) u_nk6 (
    .clk(clk), .rst(rst_b[1]), .key_valid(kv[1]), .key_ready(kr[1]), .key(key_b[1][0:191]),
    .busy(busy_b[1]), .done(done_b[1]), .rk_req(rq[1]), .rk_idx(idx[1]),
    .rk_valid(rkv[1]), .rk_err(rke[1]), .rk(rk_b[1]));

  aes_key_schedule_ctrl #(.NK(8)) u_nk8 (
    .clk(clk), .rst(rst_b[2]), .key_valid(kv[2]), .key_ready(kr[2]), .key(key_b[2][0:255]),
    .busy(busy_b[2]), .done(done_b[2]), .rk_req(rq[2]), .rk_idx(idx[2]),
    .rk_valid(rkv[2]), .rk_err(rke[2]), .rk(rk_b[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // mode: 0 plain, 1 poke rk_req/key_valid mid-expansion, 2 coincident read of idx 10, 3 reset at cycle 20
  task automatic run_key(input int u, input logic [0:255] k, input int exp_cyc,
                         input int mode, input logic [127:0] old_rk10, input string tag);
    int cyc;
    bit seen;
    key_b[u] = k;
    kv[u] = 1'b1;
    if (mode == 2) begin
      rq[u] = 1'b1;
      idx[u] = 4'd10;
    end
    @(posedge clk); #1;
    kv[u] = 1'b0;
    rq[u] = 1'b0;
    if (mode == 2) begin
      check({tag, " coinc rk_valid"}, 128'(rkv[u]), 128'd1);
      check({tag, " coinc old rk"}, rk_b[u], old_rk10);
    end
    cyc = 0;
    seen = 1'b0;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        check({tag, " busy"}, 128'(busy_b[u]), 128'd1);
        check({tag, " key_ready"}, 128'(kr[u]), 128'd0);
        check({tag, " no rk_valid after accept"}, 128'(rkv[u] && mode != 2), 128'd0);
      end
      if (mode == 1 && cyc == 6) begin
        check({tag, " rk_req in expand"}, 128'(rkv[u]), 128'd0);
        rq[u] = 1'b0;
        kv[u] = 1'b0;
      end
      if (mode == 1 && cyc == 5) begin
        rq[u] = 1'b1;
        idx[u] = 4'd0;
        key_b[u] = '0;
        kv[u] = 1'b1;
      end
      if (done_b[u]) begin
        seen = 1'b1;
        break;
      end
      if (mode == 3 && cyc == 20) begin
        rst_b[u] = 1'b1;
        #1;
        check({tag, " rst busy"}, 128'(busy_b[u]), 128'd0);
        check({tag, " rst key_ready"}, 128'(kr[u]), 128'd1);
        @(posedge clk); #1;
        check({tag, " rst done"}, 128'(done_b[u]), 128'd0);
        rst_b[u] = 1'b0;
        break;
      end
    end
    if (mode == 3) begin
      check({tag, " no early done"}, 128'(seen), 128'd0);
    end else begin
      check({tag, " latency"}, 128'(cyc), 128'(exp_cyc));
      @(posedge clk); #1;
      check({tag, " done one cycle"}, 128'(done_b[u]), 128'd0);
      check({tag, " idle busy"}, 128'(busy_b[u]), 128'd0);
    end
  endtask

  task automatic read_rk(input int u, input logic [3:0] i, input logic [127:0] exp_rk,
                         input logic exp_err, input string tag);
    rq[u] = 1'b1;
    idx[u] = i;
    @(posedge clk); #1;
    rq[u] = 1'b0;
    check({tag, " rk_valid"}, 128'(rkv[u]), 128'd1);
    check({tag, " rk_err"}, 128'(rke[u]), 128'(exp_err));
    check({tag, " rk"}, rk_b[u], exp_rk);
  endtask

  localparam logic [127:0] K128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K128R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K128RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  initial begin
    for (int u = 0; u < 3; u++) begin
      rst_b[u] = 1'b1;
      kv[u] = 1'b0;
      rq[u] = 1'b0;
      idx[u] = 4'd0;
      key_b[u] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst key_ready", 128'(kr[0]), 128'd1);
    check("rst busy", 128'(busy_b[0]), 128'd0);
    check("rst done", 128'(done_b[0]), 128'd0);
    check("rst rk_valid", 128'(rkv[0]), 128'd0);
    check("rst rk_err", 128'(rke[0]), 128'd0);
    check("rst rk", rk_b[0], 128'd0);
    for (int u = 0; u < 3; u++) rst_b[u] = 1'b0;
    @(posedge clk); #1;

    rq[0] = 1'b1;
    @(posedge clk); #1;
    rq[0] = 1'b0;
    check("idle rk_req ignored", 128'(rkv[0]), 128'd0);

    run_key(0, {K128, 128'h0}, 40, 0, 128'h0, "nk4");
    read_rk(0, 4'd0, K128, 1'b0, "nk4 r0");
    read_rk(0, 4'd1, K128R1, 1'b0, "nk4 r1");
    read_rk(0, 4'd10, K128RA, 1'b0, "nk4 r10");
    @(posedge clk); #1;
    check("nk4 hold rk_valid", 128'(rkv[0]), 128'd0);
    check("nk4 hold rk", rk_b[0], K128RA);

    run_key(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 46, 0, 128'h0, "nk6");
    rq[1] = 1'b1;
    idx[1] = 4'd12;
    @(posedge clk); #1;
    idx[1] = 4'd13;
    check("nk6 r12 rk_valid", 128'(rkv[1]), 128'd1);
    check("nk6 r12 rk", rk_b[1], 128'he98ba06f448c773c8ecc720401002202);
    @(posedge clk); #1;
    rq[1] = 1'b0;
    check("nk6 r13 rk_valid", 128'(rkv[1]), 128'd1);
    check("nk6 r13 rk_err", 128'(rke[1]), 128'd1);
    check("nk6 r13 rk", rk_b[1], 128'd0);

    run_key(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 52, 0, 128'h0, "nk8");
    read_rk(2, 4'd1, 128'h1f352c073b6108d72d9810a30914dff4, 1'b0, "nk8 r1");
    read_rk(2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b0, "nk8 r14");
    read_rk(2, 4'd15, 128'd0, 1'b1, "nk8 r15");

    run_key(0, {K128, 128'h0}, 40, 1, 128'h0, "nk4 poke");
    read_rk(0, 4'd10, K128RA, 1'b0, "nk4 poke r10");
    read_rk(0, 4'd1, K128R1, 1'b0, "nk4 poke r1");

    run_key(0, {K128, 128'h0}, 40, 3, 128'h0, "nk4 abort");
    run_key(0, {K128, 128'h0}, 40, 0, 128'h0, "nk4 after rst");
    read_rk(0, 4'd10, K128RA, 1'b0, "nk4 after rst r10");

    run_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 40, 2, K128RA, "nk4 rekey");
    read_rk(0, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b0, "nk4 rekey r10");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule_ctrl.md
Name: aes_key_schedule_ctrl

Overview:
Sequential AES key-schedule controller. It accepts a cipher key, generates the expanded word array iteratively (one 32-bit word per clock) into an internal register file, then serves 128-bit round keys to the cipher round datapath on indexed request. It replaces the wide combinational expansion in the cipher path and lets one round engine fetch keys round by round.

Parameters:
NK, 4, key length in 32-bit words (4/6/8 → AES-128/192/256); NR = NK+6 rounds, NW = 4*(NR+1) total words (44/52/60)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
key_valid  in  1  new key present
key_ready  out  1  block can accept a key
key  in  [0:32*NK-1]  cipher key; bit 0 = MSB; word0 = key[0:31]
busy  out  1  expansion in progress
done  out  1  one-cycle pulse when expansion completes
rk_req  in  1  round-key read request
rk_idx  in  4  round index 0..NR
rk_valid  out  1  rk/rk_err valid, one-cycle pulse
rk_err  out  1  request index > NR
rk  out  [0:127]  round key = words 4*idx..4*idx+3, word 4*idx in rk[0:31]

Behaviour:
- Reset (async, any state): state IDLE; key_ready=1, busy=0, done=0, rk_valid=0, rk_err=0, rk=0; word file contents don't-care, marked invalid.
- States: IDLE, EXPAND, READY.
- key_ready=1 in IDLE and READY, 0 in EXPAND. key accepted on rising edge with key_valid && key_ready.
- Accept: w[0..NK-1] <= key words; i <= NK; state → EXPAND; busy=1 from next cycle.
- EXPAND, each cycle computes w[i]:
  - temp = w[i-1].
  - i%NK==0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/NK],24'h0}; Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
  - NK==8 and i%NK==4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp; i <= i+1.
  - SubWord = AES S-box on each byte (4 S-box instances, combinational); RotWord = left byte rotate.
- When w[NW-1] is written: state → READY, busy=0, done=1 for exactly one cycle.
- Expansion latency: NW-NK cycles after acceptance (40/46/52). done asserts the cycle after the last word write.
- key_valid during EXPAND: ignored (no restart).
- key accepted in READY: re-key; round keys are invalid immediately; same sequence as from IDLE.
- Round-key read:
  - Accepted only in READY with rk_req=1.
  - Registered, 1-cycle latency: next cycle rk_valid=1 and rk = {w[4k],w[4k+1],w[4k+2],w[4k+3]} with k = rk_idx.
  - rk_idx > NR: rk_valid=1, rk_err=1, rk=0.
  - Back-to-back requests every cycle are supported.
  - rk holds its last value when rk_valid=0.
  - rk_req in IDLE/EXPAND: ignored, rk_valid stays 0.
  - rk_req coincident with key acceptance in READY: the read is served from the old key (word file updated at the same edge, read registered from pre-edge contents). Afterwards rk_req is ignored until done.
- Reset mid-EXPAND: abort to IDLE; done is never pulsed; a subsequent key restarts from i=NK.
- i counter width: 6 bits. Rcon index = i/NK, computed without a divider, via a secondary counter that wraps at NK.

Test Plan:
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c → done exactly 40 cycles after accept; rk_idx=0 → rk=2b7e151628aed2a6abf7158809cf4f3c; rk_idx=1 → a0fafe1788542cb123a339392a6c7605; rk_idx=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → done after 46 cycles; rk_idx=12 → e98ba06f448c773c8ecc720401002202; rk_idx=13 → rk_valid=1, rk_err=1, rk=0.
- NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → done after 52 cycles; rk_idx=1 → 1f352c073b6108d72d9810a30914dff4; rk_idx=14 → fe4890d1e6188d0b046df344706c631e.
- NK=4, rk_req during EXPAND and key_valid pulse during EXPAND → no rk_valid, expansion unperturbed, final keys match the first test.
- NK=4, assert rst at cycle 20 of expansion, then load key 2b7e...4f3c → done after 40 more cycles, no earlier done pulse, rk_idx=10 correct.
- NK=4, in READY: rk_req idx 10 with a simultaneous new key 000102030405060708090a0b0c0d0e0f → rk = d014f9a8...0ca6 (old key). After done, rk_idx=10 → 13111d7fe3944a17f307a78b4d2b30c5.
